// File: rtl/mem_block_mover_if.sv
// rtl/mem_block_mover_if.sv - memory-side bus between the block mover and the BRAM
//
// Purpose: bundles the single-port BRAM lines that the block mover owns.
// Signal names are written from the mover's point of view.
//   mem_addr_o    WORDS       memory address
//   mem_data_o    DATA_WIDTH  memory write data
//   mem_wr_en_no  1           memory write enable, active low
//   mem_data_i    DATA_WIDTH  memory read data (registered by the memory on negedge)
// Modports:
//   master - the block mover (drives address/data/write enable, reads data)
//   slave  - the memory (samples address/data/write enable, returns read data)
interface mem_block_mover_if #(
  parameter int WORDS      = 8,
  parameter int DATA_WIDTH = 16
);
  logic [WORDS-1:0]      mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic                  mem_wr_en_no;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport master (
    output mem_addr_o,
    output mem_data_o,
    output mem_wr_en_no,
    input  mem_data_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_data_o,
    input  mem_wr_en_no,
    output mem_data_i
  );
endinterface

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - block copy / block fill engine driving a single-port BRAM
//
// Purpose: on a start strobe, copies len words from src to dst, or fills len
// words at dst with a constant. Copy is strictly ascending and alternates one
// read cycle with one write cycle; fill writes one word per cycle.
// Ports:
//   clk_i     in   1           system clock, all registers update on posedge
//   reset_i   in   1           synchronous active-high reset
//   start_i   in   1           command strobe, only honoured in IDLE
//   mode_i    in   1           0 = copy, 1 = fill (latched with start)
//   src_i     in   WORDS       copy source base address
//   dst_i     in   WORDS       destination base address
//   len_i     in   WORDS+1     word count, 0..2^WORDS
//   fill_i    in   DATA_WIDTH  fill value
//   busy_o    out  1           command in progress (READ/WRITE cycles)
//   done_o    out  1           one-cycle completion pulse
//   mem_bus   master modport of mem_block_mover_if (address, data, write enable)
module mem_block_mover #(
  parameter int WORDS      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [WORDS-1:0]      src_i,
  input  logic [WORDS-1:0]      dst_i,
  input  logic [WORDS:0]        len_i,
  input  logic [DATA_WIDTH-1:0] fill_i,
  output logic                  busy_o,
  output logic                  done_o,
  mem_block_mover_if.master     mem_bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;

  state_t                state_q;

  // Command parameters latched at start.
  logic                  mode_q;
  logic [WORDS-1:0]      src_q;
  logic [WORDS-1:0]      dst_q;
  logic [WORDS:0]        len_q;
  logic [DATA_WIDTH-1:0] fill_q;

  // Word index; one bit wider than the address so len = 2^WORDS is reachable.
  logic [WORDS:0]        i_q;
  logic [WORDS:0]        i_d;

  // Registered outputs.
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_en_n_q;
  logic [WORDS-1:0]      addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Index of the word after the one being written this cycle.
  assign i_d = i_q + (WORDS+1)'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mode_q    <= MODE_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      i_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_n_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      // done is a single-cycle pulse; only the transition into DONE raises it.
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          wr_en_n_q <= 1'b1;
          busy_q    <= 1'b0;
          if (start_i) begin
            mode_q <= mode_i;
            src_q  <= src_i;
            dst_q  <= dst_i;
            len_q  <= len_i;
            fill_q <= fill_i;
            i_q    <= '0;
            if (len_i == '0) begin
              // Empty command: completes without ever touching memory.
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (mode_i == MODE_COPY) begin
              state_q <= READ;
              busy_q  <= 1'b1;
              addr_q  <= src_i;
            end else begin
              state_q   <= WRITE;
              busy_q    <= 1'b1;
              addr_q    <= dst_i;
              data_q    <= fill_i;
              wr_en_n_q <= 1'b0;
            end
          end
        end

        READ: begin
          // The memory updated mem_data_i on the negedge inside this cycle,
          // so it holds mem[src+i] here and becomes the write data.
          state_q   <= WRITE;
          addr_q    <= dst_q + i_q[WORDS-1:0];
          data_q    <= mem_bus.mem_data_i;
          wr_en_n_q <= 1'b0;
        end

        WRITE: begin
          i_q <= i_d;
          if (i_d == len_q) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            wr_en_n_q <= 1'b1;
          end else if (mode_q == MODE_COPY) begin
            state_q   <= READ;
            addr_q    <= src_q + i_d[WORDS-1:0];
            wr_en_n_q <= 1'b1;
          end else begin
            state_q   <= WRITE;
            addr_q    <= dst_q + i_d[WORDS-1:0];
            data_q    <= fill_q;
            wr_en_n_q <= 1'b0;
          end
        end

        DONE: begin
          // start_i is deliberately not looked at here; it is next honoured
          // in IDLE.
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          wr_en_n_q <= 1'b1;
        end

        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          wr_en_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign mem_bus.mem_addr_o   = addr_q;
  assign mem_bus.mem_data_o   = data_q;
  assign mem_bus.mem_wr_en_no = wr_en_n_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - scoreboard bench for mem_block_mover with a negedge BRAM model
module tb_mem_block_mover;

  localparam int WORDS = 8;
  localparam int DW    = 16;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            start_i;
  logic            mode_i;
  logic [WORDS-1:0] src_i;
  logic [WORDS-1:0] dst_i;
  logic [WORDS:0]  len_i;
  logic [DW-1:0]   fill_i;
  logic            busy_o;
  logic            done_o;

  mem_block_mover_if #(.WORDS(WORDS), .DATA_WIDTH(DW)) bus ();

  mem_block_mover #(.WORDS(WORDS), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .src_i   (src_i),
    .dst_i   (dst_i),
    .len_i   (len_i),
    .fill_i  (fill_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .mem_bus (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int busy_cnt = 0;

  logic [DW-1:0] mem [0:255];

  // Expected write stream {addr, data} and expected {done cycle, busy cycles}.
  logic [WORDS+DW-1:0] exp_wr_q [$];
  int                  exp_done_cyc_q [$];
  int                  exp_busy_q [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Negedge-clocked single-port BRAM, read-before-write.
  always @(negedge clk_i) begin
    bus.mem_data_i = mem[bus.mem_addr_o];
    if (bus.mem_wr_en_no === 1'b0) mem[bus.mem_addr_o] = bus.mem_data_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every write strobe must match the next expected write.
  always @(negedge clk_i) begin
    if (bus.mem_wr_en_no === 1'b0) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write_addr", {24'd0, bus.mem_addr_o}, 32'hFFFF_FFFF);
      end else begin
        logic [WORDS+DW-1:0] e;
        e = exp_wr_q.pop_front();
        check("write_addr", {24'd0, bus.mem_addr_o}, {24'd0, e[WORDS+DW-1:DW]});
        check("write_data", {16'd0, bus.mem_data_o}, {16'd0, e[DW-1:0]});
      end
    end
  end

  // Done/busy monitor: done must arrive in the expected cycle after the
  // expected number of busy cycles.
  always @(negedge clk_i) begin
    if (busy_o === 1'b1) busy_cnt++;
    if (done_o === 1'b1) begin
      if (exp_done_cyc_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("done_cycle", cyc, exp_done_cyc_q.pop_front());
        check("busy_cycles", busy_cnt, exp_busy_q.pop_front());
      end
      busy_cnt = 0;
      done_count++;
    end
  end

  task automatic push_wr(input logic [WORDS-1:0] a, input logic [DW-1:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  // Issue one command; returns #1 after the posedge that sampled start (E),
  // with e = the cycle number of the cycle following E.
  task automatic issue(input logic m, input logic [WORDS-1:0] s, input logic [WORDS-1:0] d,
                       input logic [WORDS:0] n, input logic [DW-1:0] f, input bit expect_done,
                       output int e);
    @(negedge clk_i);
    start_i = 1'b1; mode_i = m; src_i = s; dst_i = d; len_i = n; fill_i = f;
    @(posedge clk_i);
    #1;
    e = cyc;
    start_i = 1'b0;
    if (expect_done) begin
      if (m == 1'b0) begin
        exp_done_cyc_q.push_back(e + 2 * int'(n));
        exp_busy_q.push_back(2 * int'(n));
      end else begin
        exp_done_cyc_q.push_back(e + int'(n));
        exp_busy_q.push_back(int'(n));
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n0;
    bit seen;
    n0 = done_count;
    seen = 0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk_i);
      #1;
      if (done_count > n0) seen = 1;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int e;
    for (int k = 0; k < 256; k++) mem[k] = 16'hE000 | DW'(k);
    reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    src_i = '0; dst_i = '0; len_i = '0; fill_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_wr_en_n", {31'd0, bus.mem_wr_en_no}, 32'd1);
    check("rst_addr", {24'd0, bus.mem_addr_o}, 32'd0);
    check("rst_data", {16'd0, bus.mem_data_o}, 32'd0);
    reset_i = 1'b0;

    // Fill dst=0x10 len=4.
    for (int k = 0; k < 4; k++) push_wr(8'h10 + 8'(k), 16'hA5A5);
    issue(1'b1, 8'h00, 8'h10, 9'd4, 16'hA5A5, 1'b1, e);
    wait_done("fill4");
    for (int k = 0; k < 4; k++) check("fill4_mem", {16'd0, mem[8'h10 + k]}, 32'hA5A5);
    check("fill4_below", {16'd0, mem[8'h0F]}, 32'hE00F);
    check("fill4_above", {16'd0, mem[8'h14]}, 32'hE014);

    // Copy mem[0..2] -> 0x80, len=3.
    mem[0] = 16'h00FF; mem[1] = 16'h00F0; mem[2] = 16'h000F;
    push_wr(8'h80, 16'h00FF); push_wr(8'h81, 16'h00F0); push_wr(8'h82, 16'h000F);
    issue(1'b0, 8'h00, 8'h80, 9'd3, 16'h0000, 1'b1, e);
    wait_done("copy3");
    check("copy3_m80", {16'd0, mem[8'h80]}, 32'h00FF);
    check("copy3_m82", {16'd0, mem[8'h82]}, 32'h000F);
    check("copy3_m83", {16'd0, mem[8'h83]}, 32'hE083);

    // Overlapping copy src=0x20 dst=0x21 replicates mem[0x20].
    mem[8'h20] = 16'h0001;
    for (int k = 1; k <= 3; k++) push_wr(8'h20 + 8'(k), 16'h0001);
    issue(1'b0, 8'h20, 8'h21, 9'd3, 16'h0000, 1'b1, e);
    wait_done("overlap");
    check("overlap_m23", {16'd0, mem[8'h23]}, 32'h0001);
    check("overlap_m24", {16'd0, mem[8'h24]}, 32'hE024);

    // Fill wrapping past the top of memory.
    push_wr(8'hFE, 16'h1234); push_wr(8'hFF, 16'h1234);
    push_wr(8'h00, 16'h1234); push_wr(8'h01, 16'h1234);
    issue(1'b1, 8'h00, 8'hFE, 9'd4, 16'h1234, 1'b1, e);
    wait_done("wrap");
    check("wrap_mFF", {16'd0, mem[8'hFF]}, 32'h1234);
    check("wrap_m01", {16'd0, mem[8'h01]}, 32'h1234);
    check("wrap_m02", {16'd0, mem[8'h02]}, 32'h000F);

    // len=0: done next cycle, no busy, no write.
    issue(1'b1, 8'h00, 8'h40, 9'd0, 16'hBEEF, 1'b1, e);
    wait_done("len0");
    check("len0_m40", {16'd0, mem[8'h40]}, 32'hE040);

    // Start pulsed mid-copy with a different command is ignored.
    mem[8'h48] = 16'h1111; mem[8'h49] = 16'h2222; mem[8'h4A] = 16'h3333;
    push_wr(8'h50, 16'h1111); push_wr(8'h51, 16'h2222); push_wr(8'h52, 16'h3333);
    issue(1'b0, 8'h48, 8'h50, 9'd3, 16'h0000, 1'b1, e);
    @(negedge clk_i);
    start_i = 1'b1; mode_i = 1'b1; dst_i = 8'h60; len_i = 9'd2; fill_i = 16'hDEAD;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done("ignored_start");
    check("ignored_m52", {16'd0, mem[8'h52]}, 32'h3333);
    check("ignored_m60", {16'd0, mem[8'h60]}, 32'hE060);

    // Reset during the 3rd write of a len=8 fill.
    for (int k = 0; k < 3; k++) push_wr(8'h30 + 8'(k), 16'h5A5A);
    issue(1'b1, 8'h00, 8'h30, 9'd8, 16'h5A5A, 1'b0, e);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("midrst_wr_en_n", {31'd0, bus.mem_wr_en_no}, 32'd1);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_addr", {24'd0, bus.mem_addr_o}, 32'd0);
    reset_i = 1'b0;
    busy_cnt = 0;
    repeat (4) @(negedge clk_i);
    check("midrst_m32", {16'd0, mem[8'h32]}, 32'h5A5A);
    check("midrst_m33", {16'd0, mem[8'h33]}, 32'hE033);

    // Fresh start after reset.
    push_wr(8'h33, 16'h7777); push_wr(8'h34, 16'h7777);
    issue(1'b1, 8'h00, 8'h33, 9'd2, 16'h7777, 1'b1, e);
    wait_done("post_rst");
    check("post_rst_m34", {16'd0, mem[8'h34]}, 32'h7777);
    check("post_rst_m35", {16'd0, mem[8'h35]}, 32'hE035);

    // Full-length fill of all 256 words.
    for (int k = 0; k < 256; k++) push_wr(8'(8'h05 + k), 16'hC3C3);
    issue(1'b1, 8'h00, 8'h05, 9'd256, 16'hC3C3, 1'b1, e);
    wait_done("full");
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== 16'hC3C3) bad++;
      check("full_bad_words", bad, 32'd0);
    end

    repeat (3) @(negedge clk_i);
    check("wr_queue_empty", exp_wr_q.size(), 32'd0);
    check("done_queue_empty", exp_done_cyc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
